time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 10000, idle cycles in entry before abort (10 s at 1 kHz).
REQ-002 Parameter ERR_HOLD, default 500, cycles err is held after a rejected digit.
REQ-003 clk  input  1  system clock (1 kHz).
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 set_mode  input  1  set-mode switch level (1 = setting requested).
REQ-006 keypad  input  10  one-hot key lines, bit n = digit n.
REQ-007 load_ack  input  1  clock-counter accepts load_time this cycle.
REQ-008 load_valid  output  1  load_time holds a validated time awaiting acceptance.
REQ-009 load_time  output  24  BCD time {h_ten,h_one,m_ten,m_one,s_ten,s_one}, h_ten in [23:20].
REQ-010 cursor  output  3  digit position awaiting entry, 0..5.
REQ-011 entry_active  output  1  high in ENTRY and ERROR states.
REQ-012 err  output  1  high while in ERROR state.

Function
REQ-013 The block SHALL register keypad and set_mode each cycle (keypad_prev, mode_prev).
REQ-014 A key event SHALL occur only when keypad is exactly one-hot and keypad_prev == 0; multi-hot or held keys SHALL produce no event.
REQ-015 States SHALL be IDLE, ENTRY, ERROR, LOAD.
REQ-016 IDLE: on set_mode rising edge (set_mode=1, mode_prev=0) SHALL go to ENTRY next cycle with cursor=0, digit buffer cleared to 0, timeout counter 0.
REQ-017 ENTRY digit limits: pos0 <=2; pos1 <=9, or <=3 when buffered h_ten=2; pos2 <=5; pos3 <=9; pos4 <=5; pos5 <=9.
REQ-018 ENTRY valid key: digit stored at cursor position, cursor+1, timeout counter cleared; valid key at pos5 SHALL store and go to LOAD (cursor stays 5).
REQ-019 ENTRY invalid key: buffer and cursor unchanged, go to ERROR, hold counter cleared.
REQ-020 ENTRY: timeout counter increments each cycle without key event; at TIMEOUT_CYC-1 SHALL return to IDLE with no load.
REQ-021 ENTRY or ERROR with set_mode=0 SHALL abort to IDLE next cycle, no load, priority over key events and timeout.
REQ-022 ERROR: err=1; key events ignored; after ERR_HOLD cycles SHALL return to ENTRY with unchanged cursor and timeout counter cleared.
REQ-023 LOAD: load_valid=1 and load_time = buffer, both stable until acknowledged; key events and set_mode ignored.
REQ-024 LOAD with load_ack=1 SHALL go to IDLE next cycle, load_valid=0, cursor=0.
REQ-025 load_ack outside LOAD SHALL be ignored.
REQ-026 Re-entry after LOAD or abort SHALL require a new set_mode rising edge.
REQ-027 load_time SHALL reflect the buffer in all states; consumers use it only when load_valid=1.

Reset
REQ-028 rst SHALL immediately force IDLE, load_valid=0, load_time=0, cursor=0, entry_active=0, err=0, keypad_prev=0, mode_prev=0, all counters 0.
REQ-029 rst asserted mid-entry or in LOAD SHALL discard the buffer and drop load_valid without waiting for load_ack.

Verification
REQ-030 set_mode 0->1, keys 1,2,3,4,5,6 (one press each) -> LOAD, load_time=0x123456, load_valid=1 until load_ack, then IDLE.
REQ-031 Keys 2 then 4 -> ERROR, err=1 for 500 cycles, cursor=1; then key 3 accepted, cursor=2.
REQ-032 Key 7 held for 50 cycles -> exactly one event; keypad=0x003 -> no event.
REQ-033 Keys 0,9 then no key for 10000 cycles -> IDLE, load_valid never asserted.
REQ-034 set_mode dropped at cursor=3 -> IDLE next cycle; set_mode high again without edge -> remains IDLE.
REQ-035 rst pulsed in LOAD with load_ack=0 -> load_valid=0, load_time=0, state IDLE.

Source files
------------

// File: rtl/time_set_ctrl_if.sv
// Keypad time-setting bus: set-mode switch, keypad and load handshake
// between the clock counter (master side) and the setting controller.
interface time_set_ctrl_if;
  logic        set_mode;
  logic [9:0]  keypad;
  logic        load_ack;
  logic        load_valid;
  logic [23:0] load_time;
  logic [2:0]  cursor;
  logic        entry_active;
  logic        err;

  modport master (
    output set_mode, keypad, load_ack,
    input  load_valid, load_time, cursor, entry_active, err
  );

  modport slave (
    input  set_mode, keypad, load_ack,
    output load_valid, load_time, cursor, entry_active, err
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller: collects six BCD digits (HH:MM:SS) from a
// one-hot keypad, range-checks each digit against its position, and hands
// the completed time to the clock counter through a valid/ack handshake.
module time_set_ctrl #(
  parameter int TIMEOUT_CYC = 10000,
  parameter int ERR_HOLD    = 500
) (
  input logic           clk,
  input logic           rst,
  time_set_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(ERR_HOLD + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, ERROR, LOAD} state_t;

  state_t        state;
  logic [9:0]    keypad_prev;
  logic          mode_prev;
  logic [3:0]    digits [6];
  logic [2:0]    cursor;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic          load_valid_q;
  logic          entry_active_q;
  logic          err_q;

  logic          key_event;
  logic [3:0]    key_digit;
  logic [3:0]    digit_limit;
  logic          key_valid;

  // A press counts only on a clean single key arriving from an all-released keypad.
  assign key_event = $onehot(bus.keypad) && (keypad_prev == 10'd0);

  // Encode the one-hot key lines into the digit value they represent.
  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.keypad[i]) key_digit = 4'(i);
    end
  end

  // Largest digit allowed at the current cursor; hour units cap at 3 once tens is 2.
  always_comb begin
    digit_limit = 4'd9;
    case (cursor)
      3'd0:    digit_limit = 4'd2;
      3'd1:    digit_limit = (digits[0] == 4'd2) ? 4'd3 : 4'd9;
      3'd2:    digit_limit = 4'd5;
      3'd4:    digit_limit = 4'd5;
      default: digit_limit = 4'd9;
    endcase
  end

  assign key_valid = (key_digit <= digit_limit);

  // Main controller: input history registers, entry FSM, digit buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      keypad_prev    <= '0;
      mode_prev      <= 1'b0;
      cursor         <= '0;
      tcnt           <= '0;
      hcnt           <= '0;
      load_valid_q   <= 1'b0;
      entry_active_q <= 1'b0;
      err_q          <= 1'b0;
      for (int i = 0; i < 6; i++) digits[i] <= '0;
    end else begin
      keypad_prev <= bus.keypad;
      mode_prev   <= bus.set_mode;
      case (state)
        IDLE: begin
          if (bus.set_mode && !mode_prev) begin
            state          <= ENTRY;
            cursor         <= '0;
            tcnt           <= '0;
            entry_active_q <= 1'b1;
            for (int i = 0; i < 6; i++) digits[i] <= '0;
          end
        end
        ENTRY: begin
          if (!bus.set_mode) begin
            state          <= IDLE;
            cursor         <= '0;
            entry_active_q <= 1'b0;
          end else if (key_event) begin
            if (key_valid) begin
              digits[cursor] <= key_digit;
              tcnt           <= '0;
              if (cursor == 3'd5) begin
                state          <= LOAD;
                entry_active_q <= 1'b0;
                load_valid_q   <= 1'b1;
              end else begin
                cursor <= cursor + 3'd1;
              end
            end else begin
              state <= ERROR;
              hcnt  <= '0;
              err_q <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state          <= IDLE;
            cursor         <= '0;
            entry_active_q <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ERROR: begin
          if (!bus.set_mode) begin
            state          <= IDLE;
            cursor         <= '0;
            entry_active_q <= 1'b0;
            err_q          <= 1'b0;
          end else if (hcnt == HW'(ERR_HOLD - 1)) begin
            state <= ENTRY;
            tcnt  <= '0;
            err_q <= 1'b0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        LOAD: begin
          if (bus.load_ack) begin
            state        <= IDLE;
            cursor       <= '0;
            load_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_valid   = load_valid_q;
  assign bus.load_time    = {digits[0], digits[1], digits[2], digits[3], digits[4], digits[5]};
  assign bus.cursor       = cursor;
  assign bus.entry_active = entry_active_q;
  assign bus.err          = err_q;

endmodule
